element_stream_parser: RTL and testbench

Parametrised streaming parser for a complete XML/HTML tag, from `<` to `>`. It replaces fixed first-letter tag decoding with full-name matching against a packaged name table. It also adds a valid/ready character handshake, quoted attribute values with captured text, closing and self-closing detection, and error reporting. It sits between the document character source and the layout/DOM builder, and emits one record per attribute followed by one tag record.

---
 rtl/element_stream_parser_pkg.sv | 89 ++++++++
 rtl/element_stream_parser_name_matcher.sv | 78 +++++++
 rtl/element_stream_parser.sv | 227 ++++++++++++++++++++++
 tb/tb_element_stream_parser.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/element_stream_parser_pkg.sv
// Shared types for the element stream parser: id enums, name tables,
// character constants and the parser state encoding.
package parser_pkg;

    localparam int TAG_ID_W   = 3;
    localparam int ATTR_ID_W  = 3;
    localparam int NAME_TBL_W = 64;
    localparam int NUM_NAMES  = 6;

    typedef logic [NAME_TBL_W-1:0] name_t;

    typedef enum logic [TAG_ID_W-1:0] {
        TAG_UNKNOWN = 3'd0,
        TAG_DIV     = 3'd1,
        TAG_P       = 3'd2,
        TAG_BODY    = 3'd3,
        TAG_A       = 3'd4,
        TAG_IMG     = 3'd5
    } tag_id_e;

    typedef enum logic [ATTR_ID_W-1:0] {
        ATTR_UNKNOWN = 3'd0,
        ATTR_ID      = 3'd1,
        ATTR_CLASS   = 3'd2,
        ATTR_HREF    = 3'd3,
        ATTR_SRC     = 3'd4,
        ATTR_STYLE   = 3'd5
    } attr_id_e;

    // Names are lowercase ASCII, last character in the LSBs, zero-padded above.
    localparam name_t NAME_DIV   = 64'h0000_0000_0064_6976;  // "div"
    localparam name_t NAME_P     = 64'h0000_0000_0000_0070;  // "p"
    localparam name_t NAME_BODY  = 64'h0000_0000_626F_6479;  // "body"
    localparam name_t NAME_A     = 64'h0000_0000_0000_0061;  // "a"
    localparam name_t NAME_IMG   = 64'h0000_0000_0069_6D67;  // "img"
    localparam name_t NAME_ID    = 64'h0000_0000_0000_6964;  // "id"
    localparam name_t NAME_CLASS = 64'h0000_0063_6C61_7373;  // "class"
    localparam name_t NAME_HREF  = 64'h0000_0000_6872_6566;  // "href"
    localparam name_t NAME_SRC   = 64'h0000_0000_0073_7263;  // "src"
    localparam name_t NAME_STYLE = 64'h0000_0073_7479_6C65;  // "style"

    function automatic name_t tag_name(input int idx);
        case (idx)
            1:       return NAME_DIV;
            2:       return NAME_P;
            3:       return NAME_BODY;
            4:       return NAME_A;
            5:       return NAME_IMG;
            default: return '0;
        endcase
    endfunction

    function automatic name_t attr_name(input int idx);
        case (idx)
            1:       return NAME_ID;
            2:       return NAME_CLASS;
            3:       return NAME_HREF;
            4:       return NAME_SRC;
            5:       return NAME_STYLE;
            default: return '0;
        endcase
    endfunction

    localparam logic [7:0] CH_LT    = 8'h3C;
    localparam logic [7:0] CH_GT    = 8'h3E;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_DQ    = 8'h22;
    localparam logic [7:0] CH_SQ    = 8'h27;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    typedef enum logic [3:0] {
        S_IDLE,
        S_NAME_START,
        S_NAME,
        S_ATTR_WS,
        S_ATTR_NAME,
        S_ATTR_EQ,
        S_ATTR_VAL,
        S_EMIT_ATTR,
        S_SLASH,
        S_ERR,
        S_EMIT_TAG
    } state_e;

endpackage

// File: rtl/element_stream_parser_name_matcher.sv
// Collects a lowercased name one character at a time and matches it against
// the tag or attribute name table; overlong names never match.
module name_matcher
    import parser_pkg::*;
#(
    parameter int NAME_LEN = 8,
    parameter int CHAR_W   = 8,
    parameter bit IS_ATTR  = 1'b0,
    parameter int ID_W     = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              push,
    input  logic [CHAR_W-1:0] ch,
    output logic [ID_W-1:0]   id
);

    localparam int BUF_W = NAME_LEN * CHAR_W;
    localparam int LEN_W = $clog2(NAME_LEN + 1);
    localparam int CMP_W = (BUF_W > NAME_TBL_W) ? BUF_W : NAME_TBL_W;

    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              ovf_q, ovf_d;
    logic [CHAR_W-1:0] lc;

    always_comb begin
        lc = ch;
        if (ch >= CHAR_W'(8'h41) && ch <= CHAR_W'(8'h5A)) begin
            lc = ch | CHAR_W'(8'h20);
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        buf_d = buf_q;
        len_d = len_q;
        ovf_d = ovf_q;
        if (start) begin
            buf_d = BUF_W'(lc);
            len_d = LEN_W'(1);
            ovf_d = 1'b0;
        end else if (push) begin
            if (len_q == LEN_W'(NAME_LEN)) begin
                ovf_d = 1'b1;
            end else begin
                buf_d = (buf_q << CHAR_W) | BUF_W'(lc);
                len_d = len_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_q <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            len_q <= len_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        id = '0;
        if (!ovf_q) begin
            for (int i = 1; i < NUM_NAMES; i++) begin
                if (CMP_W'(buf_q) == CMP_W'(IS_ATTR ? attr_name(i) : tag_name(i))) begin
                    id = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/element_stream_parser.sv
// Streaming parser for one XML/HTML tag, emitting attribute records then a tag record.
// Define ELEMENT_PARSER_SELF_CLOSE_EN to recognise "/>" as a self-closing tag.
module element_stream_parser
    import parser_pkg::*;
#(
    parameter int CHAR_W   = 8,
    parameter int NAME_LEN = 8,
    parameter int VAL_LEN  = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        char_valid,
    input  logic [CHAR_W-1:0]           char_in,
    output logic                        char_ready,
    output logic                        tag_valid,
    input  logic                        tag_ready,
    output logic [TAG_ID_W-1:0]         tag_id,
    output logic                        tag_closing,
    output logic                        tag_self_closing,
    output logic                        tag_error,
    output logic                        attr_valid,
    input  logic                        attr_ready,
    output logic [ATTR_ID_W-1:0]        attr_id,
    output logic [VAL_LEN*CHAR_W-1:0]   attr_value,
    output logic [$clog2(VAL_LEN+1)-1:0] attr_len,
    output logic                        attr_trunc
);

    localparam int LEN_W = $clog2(VAL_LEN + 1);

    state_e                    state_q, state_d;
    logic                      tag_valid_q, tag_valid_d;
    logic [TAG_ID_W-1:0]       tag_id_q, tag_id_d;
    logic                      closing_q, closing_d;
    logic                      self_close_q, self_close_d;
    logic                      error_q, error_d;
    logic                      attr_valid_q, attr_valid_d;
    logic [ATTR_ID_W-1:0]      attr_id_q, attr_id_d;
    logic [VAL_LEN*CHAR_W-1:0] value_q, value_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic                      trunc_q, trunc_d;
    logic [CHAR_W-1:0]         quote_q, quote_d;

    logic accept, is_ws_raw, is_ws, is_lt, is_gt, is_slash;
    logic tag_start, tag_push, attr_start, attr_push;
    logic [TAG_ID_W-1:0]  tag_match;
    logic [ATTR_ID_W-1:0] attr_match;

    assign char_ready = !tag_valid_q && !attr_valid_q;
    assign accept     = char_valid && char_ready;
    assign is_lt      = (char_in == CHAR_W'(CH_LT));
    assign is_gt      = (char_in == CHAR_W'(CH_GT));
    assign is_slash   = (char_in == CHAR_W'(CH_SLASH));
    assign is_ws_raw  = (char_in == CHAR_W'(CH_SP)) || (char_in == CHAR_W'(CH_TAB)) ||
                        (char_in == CHAR_W'(CH_LF)) || (char_in == CHAR_W'(CH_CR));
`ifdef ELEMENT_PARSER_SELF_CLOSE_EN
    assign is_ws = is_ws_raw;
`else
    assign is_ws = is_ws_raw || is_slash;
`endif

    name_matcher #(.NAME_LEN(NAME_LEN), .CHAR_W(CHAR_W), .IS_ATTR(1'b0), .ID_W(TAG_ID_W)) u_tag_match (
        .clock(clock), .reset(reset), .start(tag_start), .push(tag_push), .ch(char_in), .id(tag_match)
    );

    name_matcher #(.NAME_LEN(NAME_LEN), .CHAR_W(CHAR_W), .IS_ATTR(1'b1), .ID_W(ATTR_ID_W)) u_attr_match (
        .clock(clock), .reset(reset), .start(attr_start), .push(attr_push), .ch(char_in), .id(attr_match)
    );

    always_comb begin
        state_d      = state_q;
        tag_valid_d  = tag_valid_q;
        tag_id_d     = tag_id_q;
        closing_d    = closing_q;
        self_close_d = self_close_q;
        error_d      = error_q;
        attr_valid_d = attr_valid_q;
        attr_id_d    = attr_id_q;
        value_d      = value_q;
        len_d        = len_q;
        trunc_d      = trunc_q;
        quote_d      = quote_q;
        tag_start    = 1'b0;
        tag_push     = 1'b0;
        attr_start   = 1'b0;
        attr_push    = 1'b0;

        case (state_q)
            S_IDLE: if (accept && is_lt) begin
                state_d      = S_NAME_START;
                tag_id_d     = '0;
                closing_d    = 1'b0;
                self_close_d = 1'b0;
                error_d      = 1'b0;
            end
            S_NAME_START: if (accept) begin
                if (is_lt || is_ws_raw || is_gt) state_d = S_ERR;
                else if (is_slash)               closing_d = 1'b1;
                else begin
                    tag_start = 1'b1;
                    state_d   = S_NAME;
                end
            end
            S_NAME: if (accept) begin
                if (is_lt) state_d = S_ERR;
                else if (is_ws) begin
                    tag_id_d = tag_match;
                    state_d  = S_ATTR_WS;
                end else if (is_gt) begin
                    tag_id_d    = tag_match;
                    tag_valid_d = 1'b1;
                    state_d     = S_EMIT_TAG;
`ifdef ELEMENT_PARSER_SELF_CLOSE_EN
                end else if (is_slash) begin
                    tag_id_d = tag_match;
                    state_d  = S_SLASH;
`endif
                end else tag_push = 1'b1;
            end
            S_ATTR_WS: if (accept) begin
                if (is_lt) state_d = S_ERR;
                else if (is_gt) begin
                    tag_valid_d = 1'b1;
                    state_d     = S_EMIT_TAG;
`ifdef ELEMENT_PARSER_SELF_CLOSE_EN
                end else if (is_slash) begin
                    state_d = S_SLASH;
`endif
                end else if (!is_ws) begin
                    attr_start = 1'b1;
                    state_d    = S_ATTR_NAME;
                end
            end
            S_ATTR_NAME: if (accept) begin
                if (is_lt || is_ws || is_gt) state_d = S_ERR;
                else if (char_in == CHAR_W'(CH_EQ)) begin
                    attr_id_d = attr_match;
                    state_d   = S_ATTR_EQ;
                end else attr_push = 1'b1;
            end
            S_ATTR_EQ: if (accept) begin
                if (char_in == CHAR_W'(CH_DQ) || char_in == CHAR_W'(CH_SQ)) begin
                    quote_d = char_in;
                    value_d = '0;
                    len_d   = '0;
                    trunc_d = 1'b0;
                    state_d = S_ATTR_VAL;
                end else state_d = S_ERR;
            end
            S_ATTR_VAL: if (accept) begin
                if (char_in == quote_q) begin
                    attr_valid_d = 1'b1;
                    state_d      = S_EMIT_ATTR;
                end else if (len_q < LEN_W'(VAL_LEN)) begin
                    value_d[int'(len_q)*CHAR_W +: CHAR_W] = char_in;
                    len_d = len_q + 1'b1;
                end else trunc_d = 1'b1;
            end
            S_EMIT_ATTR: if (attr_ready) begin
                attr_valid_d = 1'b0;
                state_d      = S_ATTR_WS;
            end
`ifdef ELEMENT_PARSER_SELF_CLOSE_EN
            S_SLASH: if (accept) begin
                if (is_gt) begin
                    self_close_d = 1'b1;
                    tag_valid_d  = 1'b1;
                    state_d      = S_EMIT_TAG;
                end else state_d = S_ERR;
            end
`endif
            S_ERR: if (accept && is_gt) begin
                error_d     = 1'b1;
                tag_valid_d = 1'b1;
                state_d     = S_EMIT_TAG;
            end
            S_EMIT_TAG: if (tag_ready) begin
                tag_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the wide value register is reset too, since it drives attr_value directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tag_valid_q  <= 1'b0;
            tag_id_q     <= '0;
            closing_q    <= 1'b0;
            self_close_q <= 1'b0;
            error_q      <= 1'b0;
            attr_valid_q <= 1'b0;
            attr_id_q    <= '0;
            value_q      <= '0;
            len_q        <= '0;
            trunc_q      <= 1'b0;
            quote_q      <= '0;
        end else begin
            state_q      <= state_d;
            tag_valid_q  <= tag_valid_d;
            tag_id_q     <= tag_id_d;
            closing_q    <= closing_d;
            self_close_q <= self_close_d;
            error_q      <= error_d;
            attr_valid_q <= attr_valid_d;
            attr_id_q    <= attr_id_d;
            value_q      <= value_d;
            len_q        <= len_d;
            trunc_q      <= trunc_d;
            quote_q      <= quote_d;
        end
    end

    assign tag_valid        = tag_valid_q;
    assign tag_id           = tag_id_q;
    assign tag_closing      = closing_q;
    assign tag_self_closing = self_close_q;
    assign tag_error        = error_q;
    assign attr_valid       = attr_valid_q;
    assign attr_id          = attr_id_q;
    assign attr_value       = value_q;
    assign attr_len         = len_q;
    assign attr_trunc       = trunc_q;

endmodule

// File: tb/tb_element_stream_parser.sv
// Scoreboard bench for element_stream_parser: expected records are queued as
// tags are driven and compared when the parser presents them.
module tb_element_stream_parser;
    import parser_pkg::*;

    localparam int CHAR_W   = 8;
    localparam int NAME_LEN = 8;
    localparam int VAL_LEN  = 16;
    localparam int LEN_W    = 5;
    localparam int VAL_W    = VAL_LEN * CHAR_W;
`ifdef ELEMENT_PARSER_SELF_CLOSE_EN
    localparam logic SC_EXP = 1'b1;
`else
    localparam logic SC_EXP = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              char_valid;
    logic [CHAR_W-1:0] char_in;
    logic              char_ready;
    logic              tag_valid, tag_ready;
    logic [2:0]        tag_id;
    logic              tag_closing, tag_self_closing, tag_error;
    logic              attr_valid, attr_ready;
    logic [2:0]        attr_id;
    logic [VAL_W-1:0]  attr_value;
    logic [LEN_W-1:0]  attr_len;
    logic              attr_trunc;

    element_stream_parser #(.CHAR_W(CHAR_W), .NAME_LEN(NAME_LEN), .VAL_LEN(VAL_LEN)) dut (
        .clock(clock), .reset(reset),
        .char_valid(char_valid), .char_in(char_in), .char_ready(char_ready),
        .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_id(tag_id),
        .tag_closing(tag_closing), .tag_self_closing(tag_self_closing), .tag_error(tag_error),
        .attr_valid(attr_valid), .attr_ready(attr_ready), .attr_id(attr_id),
        .attr_value(attr_value), .attr_len(attr_len), .attr_trunc(attr_trunc)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]       id;
        logic [VAL_W-1:0] value;
        logic [LEN_W-1:0] len;
        logic             trunc;
    } attr_rec_t;

    typedef struct {
        logic [2:0] id;
        logic       closing;
        logic       self_closing;
        logic       error;
    } tag_rec_t;

    attr_rec_t attr_q[$];
    tag_rec_t  tag_q[$];
    attr_rec_t ea;
    tag_rec_t  et;

    // Replaces '^' with a double-quote character.
    function automatic string dq(input string s);
        string r = s;
        for (int i = 0; i < r.len(); i++) begin
            if (r[i] == "^") r[i] = 8'h22;
        end
        return r;
    endfunction

    function automatic logic [VAL_W-1:0] pack_val(input string s);
        logic [VAL_W-1:0] v = '0;
        for (int i = 0; i < s.len() && i < VAL_LEN; i++) v[i*8 +: 8] = s[i];
        return v;
    endfunction

    task automatic expect_attr(input logic [2:0] id, input string v);
        attr_rec_t r;
        r.id    = id;
        r.value = pack_val(v);
        r.len   = LEN_W'((v.len() > VAL_LEN) ? VAL_LEN : v.len());
        r.trunc = (v.len() > VAL_LEN);
        attr_q.push_back(r);
    endtask

    task automatic expect_tag(input logic [2:0] id, input logic cl, input logic sc, input logic er);
        tag_rec_t r;
        r.id           = id;
        r.closing      = cl;
        r.self_closing = sc;
        r.error        = er;
        tag_q.push_back(r);
    endtask

    // Records are compared at the one sample where valid and ready are both high.
    always @(negedge clock) begin
        if (!reset && attr_valid && attr_ready) begin
            if (attr_q.size() == 0) check("attr_unexpected", 1, 0);
            else begin
                ea = attr_q.pop_front();
                check("attr_id", attr_id, ea.id);
                check("attr_value", attr_value, ea.value);
                check("attr_len", attr_len, ea.len);
                check("attr_trunc", attr_trunc, ea.trunc);
            end
        end
        if (!reset && tag_valid && tag_ready) begin
            if (tag_q.size() == 0) check("tag_unexpected", 1, 0);
            else begin
                et = tag_q.pop_front();
                check("tag_id", tag_id, et.id);
                check("tag_closing", tag_closing, et.closing);
                check("tag_self_closing", tag_self_closing, et.self_closing);
                check("tag_error", tag_error, et.error);
            end
        end
    end

    task automatic put_char(input logic [7:0] c);
        logic acc = 1'b0;
        int   n   = 0;
        char_in    = c;
        char_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clock);
            acc = char_ready;
            @(posedge clock);
            #1;
            n++;
        end
        char_valid = 1'b0;
        if (!acc) check("char_accept_timeout", 0, 1);
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) put_char(s[i]);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((attr_q.size() != 0 || tag_q.size() != 0) && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, attr_q.size() + tag_q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        char_valid = 1'b0;
        char_in    = '0;
        tag_ready  = 1'b1;
        attr_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        check("rst_tag_valid", tag_valid, 0);
        check("rst_attr_valid", attr_valid, 0);
        check("rst_char_ready", char_ready, 1);
        check("rst_tag_fields", {tag_id, tag_closing, tag_self_closing, tag_error}, 0);
        check("rst_attr_fields", {attr_id, attr_value, attr_len, attr_trunc}, 0);

        expect_tag(TAG_DIV, 1'b0, 1'b0, 1'b0);
        send("<div");
        put_char(">");
        check("div_tag_latency", tag_valid, 1);
        check("div_char_ready_low", char_ready, 0);
        drain("div_drain");

        expect_tag(TAG_BODY, 1'b1, 1'b0, 1'b0);
        send("</BODY>");
        drain("body_drain");

        expect_attr(ATTR_HREF, "x>y");
        expect_attr(ATTR_CLASS, "c");
        expect_tag(TAG_A, 1'b0, 1'b0, 1'b0);
        send(dq("<a href=^x>y^ class='c'>"));
        drain("a_drain");

        expect_attr(ATTR_SRC, "qqqqqqqqqqqqqqqqqqqq");
        expect_tag(TAG_IMG, 1'b0, SC_EXP, 1'b0);
        send(dq("<img src=^qqqqqqqqqqqqqqqqqqqq^/>"));
        drain("img_drain");

        expect_tag(TAG_P, 1'b0, 1'b0, 1'b1);
        send("<p id=5>");
        expect_tag(TAG_P, 1'b0, 1'b0, 1'b0);
        send("<p>");
        drain("p_drain");

        expect_tag(TAG_UNKNOWN, 1'b0, 1'b0, 1'b0);
        send("<divdivdiv>");
        expect_attr(ATTR_UNKNOWN, "1");
        expect_attr(ATTR_STYLE, "");
        expect_tag(TAG_DIV, 1'b0, 1'b0, 1'b0);
        send(dq("<div foo=^1^ STYLE=^^>"));
        drain("unknown_drain");

        // Hold the attribute record for five cycles.
        expect_attr(ATTR_ID, "xy");
        send(dq("<div id=^xy"));
        attr_ready = 1'b0;
        put_char(8'h22);
        for (int i = 0; i < 5; i++) begin
            check("stall_attr_valid", attr_valid, 1);
            check("stall_char_ready", char_ready, 0);
            check("stall_attr_value", attr_value, pack_val("xy"));
            check("stall_attr_id", attr_id, ATTR_ID);
            @(posedge clock);
            #1;
        end
        attr_ready = 1'b1;
        @(posedge clock);
        #1;
        check("stall_valid_drop", attr_valid, 0);
        check("stall_ready_back", char_ready, 1);
        expect_tag(TAG_DIV, 1'b0, 1'b0, 1'b0);
        send(">");
        drain("stall_drain");

        send(dq("<div class=^abc"));
        check("pre_reset_len", attr_len, 3);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_valids", {tag_valid, attr_valid}, 0);
        check("mid_rst_tag_fields", {tag_id, tag_closing, tag_self_closing, tag_error}, 0);
        check("mid_rst_attr_fields", {attr_id, attr_value, attr_len, attr_trunc}, 0);
        reset = 1'b0;
        check("mid_rst_char_ready", char_ready, 1);
        expect_tag(TAG_DIV, 1'b0, 1'b0, 1'b0);
        send("<div>");
        drain("post_reset_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
